ram_port_arbiter: RTL and testbench

- Arbitrates one single-port 2-bit RAM between two requesters, A and B.
- Grants are round-robin.
- For each accepted request, the block sequences one RAM access: it drives the enable and write strobes, captures read data, and returns a done pulse to the winning requester.
- Sits between requester logic and the RAM port. It also keeps a count of completed transactions per requester.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_port_arbiter_rr_pick2.sv | 23 ++
 rtl/ram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester RAM port arbiter.
package ram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 2;
    localparam int unsigned DEF_DATA_W = 2;
    localparam int unsigned DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin chooser; on a tie the requester that
// was not granted last wins.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = REQ_A;
        if (req_a && req_b) begin
            winner = (last == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            winner = REQ_B;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sequencing one access at a time on a single-port RAM
// for requesters A and B, with per-requester completion counters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  a_cnt,
    output logic [CNT_W-1:0]  b_cnt
);

    state_t             state, state_next;
    logic               last, last_next;
    logic               pick_valid, pick_winner;
    logic               a_gnt_next, b_gnt_next, a_done_next, b_done_next;
    logic               mem_en_next, mem_we_next, busy_next;
    logic [ADDR_W-1:0]  mem_addr_next;
    logic [DATA_W-1:0]  mem_wdata_next, a_rdata_next, b_rdata_next;
    logic [CNT_W-1:0]   a_cnt_next, b_cnt_next;

    rr_pick2 u_pick (
        .req_a  (a_req),
        .req_b  (b_req),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // The mem_* registers double as the latched command; last identifies
    // the owner of the transaction in flight.
    always_comb begin
        state_next     = state;
        last_next      = last;
        a_gnt_next     = 1'b0;
        b_gnt_next     = 1'b0;
        a_done_next    = 1'b0;
        b_done_next    = 1'b0;
        mem_en_next    = 1'b0;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        a_rdata_next   = a_rdata;
        b_rdata_next   = b_rdata;
        a_cnt_next     = a_cnt;
        b_cnt_next     = b_cnt;
        busy_next      = busy;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (pick_valid) begin
                    state_next  = ACCESS;
                    last_next   = pick_winner;
                    busy_next   = 1'b1;
                    mem_en_next = 1'b1;
                    if (pick_winner == REQ_A) begin
                        a_gnt_next     = 1'b1;
                        mem_we_next    = a_we;
                        mem_addr_next  = a_addr;
                        mem_wdata_next = a_wdata;
                    end else begin
                        b_gnt_next     = 1'b1;
                        mem_we_next    = b_we;
                        mem_addr_next  = b_addr;
                        mem_wdata_next = b_wdata;
                    end
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                if (last == REQ_A) begin
                    a_done_next = 1'b1;
                    a_cnt_next  = a_cnt + CNT_W'(1);
                    if (!mem_we) a_rdata_next = mem_rdata;
                end else begin
                    b_done_next = 1'b1;
                    b_cnt_next  = b_cnt + CNT_W'(1);
                    if (!mem_we) b_rdata_next = mem_rdata;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= REQ_B;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_cnt     <= '0;
            b_cnt     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            a_gnt     <= a_gnt_next;
            b_gnt     <= b_gnt_next;
            a_done    <= a_done_next;
            b_done    <= b_done_next;
            mem_en    <= mem_en_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            a_rdata   <= a_rdata_next;
            b_rdata   <= b_rdata_next;
            a_cnt     <= a_cnt_next;
            b_cnt     <= b_cnt_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a small RAM model answers the port,
// a monitor matches grants and completions against expected transactions.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [1:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic       a_gnt, a_done, b_gnt, b_done;
    logic [1:0] a_rdata, b_rdata;
    logic       mem_en, mem_we, busy;
    logic [1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0] a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       who;
        logic       we;
        logic [1:0] addr;
        logic [1:0] wdata;
        logic [1:0] rdata;
    } txn_t;

    txn_t gnt_q[$];
    txn_t done_q[$];
    logic [1:0] ref_mem[4];
    logic [1:0] ram[4];
    logic [1:0] ram_q = '0;
    logic [1:0] exp_a_rdata = '0, exp_b_rdata = '0;
    logic       prev_mem_en = 1'b0;
    int         gnt_age = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .a_cnt(a_cnt), .b_cnt(b_cnt)
    );

    // RAM device: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    // Monitor: grants checked against the expected order, then completions
    always @(negedge clk) begin
        if (reset) begin
            gnt_q.delete();
            done_q.delete();
            exp_a_rdata = '0;
            exp_b_rdata = '0;
            prev_mem_en = 1'b0;
        end else begin
            txn_t t;
            gnt_age++;
            if (mem_en) begin
                checks++;
                if (prev_mem_en) begin
                    errors++;
                    $display("FAIL mem_en_pulse: mem_en high two cycles in a row (required single cycle)");
                end
            end
            prev_mem_en = mem_en;
            if (a_gnt || b_gnt) begin
                checks++;
                if (gnt_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_gnt: a_gnt=%0b b_gnt=%0b with nothing expected", a_gnt, b_gnt);
                end else begin
                    t = gnt_q.pop_front();
                    if ({a_gnt, b_gnt} !== (t.who ? 2'b01 : 2'b10) || mem_en !== 1'b1 ||
                        mem_we !== t.we || mem_addr !== t.addr || busy !== 1'b1 ||
                        (t.we && mem_wdata !== t.wdata)) begin
                        errors++;
                        $display("FAIL grant: a_gnt=%0b b_gnt=%0b en=%0b we=%0b addr=%0d wdata=%0d busy=%0b, required who=%0s we=%0b addr=%0d wdata=%0d",
                                 a_gnt, b_gnt, mem_en, mem_we, mem_addr, mem_wdata, busy,
                                 t.who ? "B" : "A", t.we, t.addr, t.wdata);
                    end
                    done_q.push_back(t);
                    gnt_age = 0;
                end
            end
            if (a_done || b_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: a_done=%0b b_done=%0b", a_done, b_done);
                end else begin
                    t = done_q.pop_front();
                    if (t.who == 1'b0 && !t.we) exp_a_rdata = t.rdata;
                    if (t.who == 1'b1 && !t.we) exp_b_rdata = t.rdata;
                    if ({a_done, b_done} !== (t.who ? 2'b01 : 2'b10) || gnt_age != 2 ||
                        a_rdata !== exp_a_rdata || b_rdata !== exp_b_rdata || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL done: a_done=%0b b_done=%0b age=%0d a_rdata=%0d b_rdata=%0d busy=%0b, required who=%0s age=2 a_rdata=%0d b_rdata=%0d busy=0",
                                 a_done, b_done, gnt_age, a_rdata, b_rdata, busy,
                                 t.who ? "B" : "A", exp_a_rdata, exp_b_rdata);
                    end
                end
            end
        end
    end

    task automatic expect_txn(input logic who, input logic we, input logic [1:0] addr,
                              input logic [1:0] wdata);
        txn_t t;
        t.who = who; t.we = we; t.addr = addr; t.wdata = wdata;
        t.rdata = we ? 2'b00 : ref_mem[addr];
        if (we) ref_mem[addr] = wdata;
        gnt_q.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_txn(input logic who, input logic we, input logic [1:0] addr,
                           input logic [1:0] wdata);
        bit seen = 1'b0;
        expect_txn(who, we, addr, wdata);
        @(negedge clk);
        if (who) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else     begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = who ? b_gnt : a_gnt;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL gnt_timeout: no grant for %0s within 10 cycles", who ? "B" : "A");
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = who ? b_done : a_done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no done for %0s within 10 cycles", who ? "B" : "A");
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, a_done, a_rdata, b_gnt, b_done, b_rdata, mem_en, mem_we,
                 mem_addr, mem_wdata, busy, a_cnt, b_cnt} !== 23'd0) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d mem_en=%0b busy=%0b a_cnt=%0d b_cnt=%0d, required all 0",
                         i, mem_en, busy, a_cnt, b_cnt);
            end
        end
    endtask

    task automatic test_write();
        run_txn(1'b0, 1'b1, 2'b10, 2'b11);
        checks++;
        if (a_cnt !== 4'd1 || b_cnt !== 4'd0 || b_gnt !== 1'b0 || b_done !== 1'b0 ||
            b_rdata !== 2'b00) begin
            errors++;
            $display("FAIL write_counts: a_cnt=%0d b_cnt=%0d b_gnt=%0b b_done=%0b b_rdata=%0d, required 1 0 0 0 0",
                     a_cnt, b_cnt, b_gnt, b_done, b_rdata);
        end
    endtask

    task automatic test_read();
        run_txn(1'b0, 1'b0, 2'b10, 2'b00);
        @(negedge clk);
        checks++;
        if (a_done !== 1'b0 || a_rdata !== 2'b11 || a_cnt !== 4'd2) begin
            errors++;
            $display("FAIL read_hold: a_done=%0b a_rdata=%0d a_cnt=%0d, required 0 3 2",
                     a_done, a_rdata, a_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int grants = 0;
        int last_cyc = 0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            expect_txn(1'b0, 1'b1, 2'b00, 2'b01);
            expect_txn(1'b1, 1'b1, 2'b01, 2'b10);
        end
        a_we = 1'b1; a_addr = 2'b00; a_wdata = 2'b01;
        b_we = 1'b1; b_addr = 2'b01; b_wdata = 2'b10;
        a_req = 1'b1;
        b_req = 1'b1;
        for (int cyc = 1; cyc <= 20 && grants < 4; cyc++) begin
            @(negedge clk);
            if (a_gnt || b_gnt) begin
                grants++;
                if (grants > 1) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++;
                        $display("FAIL grant_spacing: %0d cycles between grants, required 3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL tie_grants: %0d grants seen, required 4", grants);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (a_cnt !== 4'd2 || b_cnt !== 4'd2 || busy !== 1'b0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL tie_counts: a_cnt=%0d b_cnt=%0d busy=%0b pending=%0d, required 2 2 0 0",
                     a_cnt, b_cnt, busy, done_q.size());
        end
    endtask

    task automatic test_reset_in_access();
        bit seen = 1'b0;
        expect_txn(1'b1, 1'b0, 2'b00, 2'b00);
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 2'b00;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = b_gnt;
        end
        b_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_gnt_timeout: B never granted");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || b_gnt !== 1'b0 || b_done !== 1'b0 || b_cnt !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: mem_en=%0b b_gnt=%0b b_done=%0b b_cnt=%0d busy=%0b, required all 0",
                     mem_en, b_gnt, b_done, b_cnt, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (b_done !== 1'b0 || b_cnt !== 4'd0) begin
                errors++;
                $display("FAIL abort_no_done: b_done=%0b b_cnt=%0d, required 0 0", b_done, b_cnt);
            end
        end
        // Both request after the abort: A must win
        expect_txn(1'b0, 1'b0, 2'b01, 2'b00);
        a_req = 1'b1; a_we = 1'b0; a_addr = 2'b01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = a_gnt | b_gnt;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_winner: a_gnt=%0b b_gnt=%0b, required A", a_gnt, b_gnt);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        do_reset();
        run_txn(1'b0, 1'b1, 2'b11, 2'b10);
        for (int i = 0; i < 16; i++) begin
            run_txn(1'b1, 1'(i % 2), 2'(i), 2'($urandom_range(0, 3)));
            if (i == 14) begin
                checks++;
                if (b_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL cnt_top: b_cnt=%0d, required 15", b_cnt);
                end
            end
        end
        checks++;
        if (b_cnt !== 4'd0 || a_cnt !== 4'd1) begin
            errors++;
            $display("FAIL cnt_wrap: b_cnt=%0d a_cnt=%0d, required 0 1", b_cnt, a_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ram[i] = 2'b00;
            ref_mem[i] = 2'b00;
        end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_in_access();
        test_counter_wrap();
        repeat (2) @(negedge clk);
        checks++;
        if (gnt_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d grants and %0d completions outstanding, required 0 0",
                     gnt_q.size(), done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
